// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and sizing helpers for the sequential multiplier
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // Counter must be able to represent every value from 0 to WORD_WIDTH.
    function automatic int unsigned cnt_width(input int unsigned word_width);
        return $clog2(word_width + 1);
    endfunction

endpackage

// File: rtl/claa.sv
// rtl/claa.sv - carry-lookahead adder, WORD_WIDTH bits with carry in and carry out
module claa #(
    parameter int WORD_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0] a_i,
    input  logic [WORD_WIDTH-1:0] b_i,
    input  logic                  c_i,
    output logic [WORD_WIDTH-1:0] s_o,
    output logic                  c_o
);

    logic [WORD_WIDTH-1:0] gen;
    logic [WORD_WIDTH-1:0] prop;
    logic [WORD_WIDTH:0]   carry;
    logic                  prop_run;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;

    // Each carry is a flat sum of generate terms gated by the run of propagates above them.
    always_comb begin
        carry    = '0;
        prop_run = 1'b0;
        carry[0] = c_i;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            carry[i+1] = gen[i];
            prop_run   = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                carry[i+1] = carry[i+1] | (prop_run & gen[j]);
                prop_run   = prop_run & prop[j];
            end
            carry[i+1] = carry[i+1] | (prop_run & c_i);
        end
    end

    assign s_o = prop ^ carry[WORD_WIDTH-1:0];
    assign c_o = carry[WORD_WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - multi-cycle unsigned shift-and-add multiplier with valid/ready
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [WORD_WIDTH-1:0]   a_i,
    input  logic [WORD_WIDTH-1:0]   b_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [2*WORD_WIDTH-1:0] p_o,
    output logic                    busy_o
);

    localparam int CW = int'(cnt_width(WORD_WIDTH));
    localparam logic [CW-1:0] LAST_CNT = CW'(WORD_WIDTH - 1);

    mul_state_e state;
    mul_state_e state_next;

    logic [WORD_WIDTH-1:0]   mcand;
    logic [2*WORD_WIDTH-1:0] prod;
    logic [CW-1:0]           cnt;

    logic [WORD_WIDTH-1:0]   addend;
    logic [WORD_WIDTH-1:0]   sum;
    logic                    sum_carry;
    logic [2*WORD_WIDTH-1:0] prod_step;
    logic                    accept;

    // Upper half accumulates; the multiplier bits drain out of the lower half as it shifts.
    assign addend = prod[0] ? mcand : '0;

    claa #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_claa (
        .a_i (prod[2*WORD_WIDTH-1:WORD_WIDTH]),
        .b_i (addend),
        .c_i (1'b0),
        .s_o (sum),
        .c_o (sum_carry)
    );

    assign prod_step = {sum_carry, sum, prod[WORD_WIDTH-1:1]};
    assign accept    = valid_i && (state == MUL_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= MUL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_o    = 1'b0;
        busy_o     = 1'b0;
        valid_o    = 1'b0;
        case (state)
            MUL_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    state_next = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                busy_o = 1'b1;
                if (cnt == LAST_CNT) begin
                    state_next = MUL_DONE;
                end
            end
            MUL_DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_next = MUL_IDLE;
                end
            end
            default: begin
                state_next = MUL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
        end else if (accept) begin
            mcand <= a_i;
            prod  <= {{WORD_WIDTH{1'b0}}, b_i};
            cnt   <= '0;
        end else if (state == MUL_BUSY) begin
            prod <= prod_step;
            cnt  <= cnt + CW'(1);
        end
    end

    assign p_o = prod;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - randomized self-checking bench for seq_multiplier
module tb_seq_multiplier;

    localparam int W = 8;

    logic           clk_i;
    logic           rst_ni;
    logic           valid_i;
    logic           ready_o;
    logic [W-1:0]   a_i;
    logic [W-1:0]   b_i;
    logic           valid_o;
    logic           ready_i;
    logic [2*W-1:0] p_o;
    logic           busy_o;

    int total;
    int bad;
    int cycle;

    seq_multiplier #(.WORD_WIDTH(W)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .p_o     (p_o),
        .busy_o  (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        cycle++;
    endtask

    // One transaction: reference product is plain a*b; latency is WORD_WIDTH edges.
    task automatic run_op(input int a, input int b, input int hold);
        int n;
        int exp;
        exp     = (a * b) & 32'hFFFF;
        a_i     = W'(a);
        b_i     = W'(b);
        valid_i = 1'b1;
        ready_i = (hold == 0);
        check_val("ready_before_accept", 32'(ready_o), 1);
        step();
        valid_i = 1'b0;
        check_val("busy_after_accept", 32'(busy_o), 1);
        n = 0;
        while (!valid_o && n < 50) begin
            step();
            n++;
        end
        check_val("latency", n, W);
        check_val("product", 32'(p_o), exp);
        check_val("busy_in_done", 32'(busy_o), 0);
        for (int h = 0; h < hold; h++) begin
            valid_i = h[0];
            a_i     = 1;
            b_i     = 1;
            step();
            check_val("hold_valid", 32'(valid_o), 1);
            check_val("hold_product", 32'(p_o), exp);
            check_val("hold_ready", 32'(ready_o), 0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        check_val("valid_after_hs", 32'(valid_o), 0);
        check_val("ready_after_hs", 32'(ready_o), 1);
    endtask

    initial begin
        int idx;
        int seen;
        int last_rise;
        logic prev_valid;
        logic acc;
        int qa[3];
        int qb[3];
        total   = 0;
        bad     = 0;
        cycle   = 0;
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        a_i     = '0;
        b_i     = '0;
        step();
        step();
        check_val("rst_p", 32'(p_o), 0);
        check_val("rst_valid", 32'(valid_o), 0);
        check_val("rst_busy", 32'(busy_o), 0);
        check_val("rst_ready", 32'(ready_o), 1);
        rst_ni = 1'b1;
        step();

        run_op(13, 11, 0);
        run_op(255, 255, 0);
        run_op(0, 200, 0);
        run_op(200, 0, 0);
        run_op(7, 9, 20);
        run_op(5, 6, 0);

        // Asynchronous abort part-way through the iteration.
        a_i     = 100;
        b_i     = 3;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_val("busy_mid_op", 32'(busy_o), 1);
        #2 rst_ni = 1'b0;
        #1;
        check_val("abort_p", 32'(p_o), 0);
        check_val("abort_valid", 32'(valid_o), 0);
        check_val("abort_busy", 32'(busy_o), 0);
        check_val("abort_ready", 32'(ready_o), 1);
        step();
        rst_ni = 1'b1;
        step();
        run_op(100, 3, 0);

        for (int r = 0; r < 25; r++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 3)));
        end
        run_op(255, 1, 0);
        run_op(1, 255, 0);

        // Back-to-back with valid_i held high throughout.
        qa = '{2, 4, 6};
        qb = '{3, 5, 7};
        idx        = 0;
        seen       = 0;
        last_rise  = -1;
        prev_valid = 1'b0;
        ready_i    = 1'b1;
        for (int c = 0; c < 120 && seen < 3; c++) begin
            valid_i = (idx < 3);
            a_i     = (idx < 3) ? W'(qa[idx]) : '0;
            b_i     = (idx < 3) ? W'(qb[idx]) : '0;
            acc     = valid_i && ready_o;
            step();
            if (acc) idx++;
            if (valid_o && !prev_valid) begin
                check_val("b2b_product", 32'(p_o), qa[seen] * qb[seen]);
                if (last_rise >= 0) check_val("b2b_spacing", cycle - last_rise, W + 2);
                last_rise = cycle;
                seen++;
            end
            prev_valid = valid_o;
        end
        valid_i = 1'b0;
        check_val("b2b_count", seen, 3);
        check_val("b2b_accepts", idx, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
